// File: rtl/fifo_row_unpacker_if.sv
// Bundle of the control, FIFO read-side and element-stream signals of
// fifo_row_unpacker. The master side is the unpacker itself; the slave side
// is its environment (FIFO, sequencer and scratchpad writer).
interface fifo_row_unpacker_if #(
    parameter int R_DATA_WIDTH = 64,
    parameter int ELEM_WIDTH   = 16,
    parameter int MAX_ROW_LEN  = 256
);
    localparam int ADDR_W = $clog2(MAX_ROW_LEN);
    localparam int LEN_W  = $clog2(MAX_ROW_LEN + 1);

    logic                    start;
    logic [LEN_W-1:0]        row_len;
    logic                    fifo_empty_flag;
    logic                    fifo_read_request;
    logic [R_DATA_WIDTH-1:0] fifo_rd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ELEM_WIDTH-1:0]   out_data;
    logic [ADDR_W-1:0]       out_addr;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, row_len, fifo_empty_flag, fifo_rd_data, out_ready,
        output fifo_read_request, out_valid, out_data, out_addr, out_last,
               busy, done
    );

    modport slave (
        output start, row_len, fifo_empty_flag, fifo_rd_data, out_ready,
        input  fifo_read_request, out_valid, out_data, out_addr, out_last,
               busy, done
    );
endinterface

// File: rtl/fifo_row_unpacker.sv
// Read-side unpacker for the PE input FIFO: pops packed words, splits them
// LSB-first into elements and streams one row of row_len elements per start
// pulse to the scratchpad writer with address and last-of-row flag.
// No prefetch: each word costs a FETCH and a CAPT cycle before it drains.
module fifo_row_unpacker #(
    parameter int R_DATA_WIDTH = 64,
    parameter int ELEM_WIDTH   = 16,
    parameter int MAX_ROW_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_row_unpacker_if.master   bus
);
    localparam int EPW    = R_DATA_WIDTH / ELEM_WIDTH;
    localparam int ADDR_W = $clog2(MAX_ROW_LEN);
    localparam int LEN_W  = $clog2(MAX_ROW_LEN + 1);
    localparam int IDX_W  = (EPW > 1) ? $clog2(EPW) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(EPW - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [R_DATA_WIDTH-1:0] word_r;
    logic [IDX_W-1:0]        elem_idx_r;
    logic [ADDR_W-1:0]       out_addr_r;
    logic [LEN_W-1:0]        remaining_r;

    logic pop_s;
    logic valid_s;
    logic last_s;
    logic done_s;
    logic fire_s;
    logic accept_s;

    // Next-state and output decode; every output is a function of the state
    // register except the FIFO pop, which must track the empty flag directly.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        valid_s      = 1'b0;
        last_s       = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.row_len != LEN_ZERO) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                pop_s = !bus.fifo_empty_flag;
                if (pop_s) begin
                    next_state_s = CAPT;
                end else begin
                    next_state_s = FETCH;
                end
            end
            CAPT: begin
                next_state_s = DRAIN;
            end
            DRAIN: begin
                valid_s = 1'b1;
                last_s  = (remaining_r == LEN_ONE);
                if (bus.out_ready) begin
                    if (remaining_r == LEN_ONE) begin
                        next_state_s = DONE;
                    end else if (elem_idx_r == LAST_IDX) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE: begin
                done_s       = 1'b1;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign fire_s   = valid_s && bus.out_ready;
    assign accept_s = (state_r == IDLE) && bus.start && (bus.row_len != LEN_ZERO);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Row bookkeeping and word capture; counters advance only on an accepted element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r      <= {R_DATA_WIDTH{1'b0}};
            elem_idx_r  <= IDX_ZERO;
            out_addr_r  <= ADDR_ZERO;
            remaining_r <= LEN_ZERO;
        end else if (accept_s) begin
            elem_idx_r  <= IDX_ZERO;
            out_addr_r  <= ADDR_ZERO;
            remaining_r <= bus.row_len;
        end else if (state_r == CAPT) begin
            word_r <= bus.fifo_rd_data;
        end else if (fire_s) begin
            out_addr_r  <= out_addr_r + ADDR_ONE;
            remaining_r <= remaining_r - LEN_ONE;
            if (elem_idx_r == LAST_IDX) begin
                elem_idx_r <= IDX_ZERO;
            end else begin
                elem_idx_r <= elem_idx_r + IDX_ONE;
            end
        end else begin
            word_r <= word_r;
        end
    end

    assign bus.fifo_read_request = pop_s;
    assign bus.out_valid         = valid_s;
    assign bus.out_data          = word_r[elem_idx_r * ELEM_WIDTH +: ELEM_WIDTH];
    assign bus.out_addr          = out_addr_r;
    assign bus.out_last          = last_s;
    assign bus.busy              = (state_r != IDLE);
    assign bus.done              = done_s;

endmodule

// File: tb/tb_fifo_row_unpacker.sv
// Scoreboard bench for fifo_row_unpacker: a queue-based FIFO model feeds the
// DUT, expected elements are derived from the row's words when start is
// issued, and a negedge monitor pops and compares every accepted element.
module tb_fifo_row_unpacker;
    localparam int RW  = 64;
    localparam int EW  = 16;
    localparam int MRL = 256;
    localparam int EPW = RW / EW;
    localparam int AW  = $clog2(MRL);
    localparam int LW  = $clog2(MRL + 1);

    typedef struct packed {
        logic [EW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_row_unpacker_if #(.R_DATA_WIDTH(RW), .ELEM_WIDTH(EW), .MAX_ROW_LEN(MRL)) bus();

    fifo_row_unpacker #(.R_DATA_WIDTH(RW), .ELEM_WIDTH(EW), .MAX_ROW_LEN(MRL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // FIFO model: unbounded queue, read data appears the cycle after a pop.
    logic [RW-1:0] fifo_q[$];
    int            pushed = 0;
    int            popped = 0;
    logic [RW-1:0] rd_data_r = '0;
    assign bus.fifo_empty_flag = (pushed == popped);
    assign bus.fifo_rd_data    = rd_data_r;

    // Pop the model FIFO whenever the DUT requests a word.
    always @(posedge clk) begin
        if (bus.fifo_read_request && fifo_q.size() > 0) begin
            rd_data_r <= fifo_q.pop_front();
            popped    <= popped + 1;
        end
    end

    // Downstream ready: fixed level or a fresh random bit every cycle.
    logic ready_fixed;
    logic rand_mode;
    logic rand_ready = 1'b0;
    assign bus.out_ready = rand_mode ? rand_ready : ready_fixed;
    always @(posedge clk) rand_ready <= 1'($urandom_range(0, 1));

    exp_t          exp_q[$];
    chk_t          chk_q[$];
    logic [RW-1:0] row_words[$];
    int            compared   = 0;
    int            mismatched = 0;
    int            hs_count   = 0;
    int            done_count = 0;

    task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
        chk_t c;
        c.name = nm;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    // Monitor: sole owner of the counters; drains posted checks and scores the stream.
    initial begin
        exp_t e;
        exp_t got;
        exp_t prev;
        chk_t c;
        logic stall_prev;
        logic done_prev;
        stall_prev = 1'b0;
        done_prev  = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                compared++;
                if (c.act !== c.exp) begin
                    mismatched++;
                    $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.exp);
                end
            end
            if (!reset) begin
                got = '{data: bus.out_data, addr: bus.out_addr, last: bus.out_last};
                if (stall_prev) begin
                    compared++;
                    if (!bus.out_valid || got !== prev) begin
                        mismatched++;
                        $display("FAIL hold: got v=%0b %h, expected v=1 %h", bus.out_valid, got, prev);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    compared++;
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL element: got d=%0h a=%0d l=%0b, expected none", got.data, got.addr, got.last);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            mismatched++;
                            $display("FAIL element: got d=%0h a=%0d l=%0b, expected d=%0h a=%0d l=%0b",
                                     got.data, got.addr, got.last, e.data, e.addr, e.last);
                        end
                    end
                end
                if (bus.fifo_read_request) begin
                    compared++;
                    if (bus.fifo_empty_flag) begin
                        mismatched++;
                        $display("FAIL pop_empty: got request with empty FIFO, expected none");
                    end
                end
                if (bus.done) begin
                    compared++;
                    done_count++;
                    if (done_prev) begin
                        mismatched++;
                        $display("FAIL done_width: got 2-cycle done, expected 1");
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                done_prev  = bus.done;
                prev       = got;
            end else begin
                stall_prev = 1'b0;
                done_prev  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [RW-1:0] w);
        fifo_q.push_back(w);
        pushed++;
    endtask

    task automatic rand_words(input int n, input bit preload);
        logic [RW-1:0] w;
        row_words.delete();
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            row_words.push_back(w);
            if (preload) push_word(w);
        end
    endtask

    // Reference model: element k is slice k%EPW of word k/EPW, at address k.
    task automatic issue_start(input int len);
        logic [RW-1:0] w;
        exp_t e;
        for (int k = 0; k < len; k++) begin
            w      = row_words[k / EPW];
            e.data = EW'(w >> (EW * (k % EPW)));
            e.addr = AW'(k);
            e.last = (k == len - 1);
            exp_q.push_back(e);
        end
        bus.start   = 1'b1;
        bus.row_len = LW'(len);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, output int first, output int dn);
        first = -1;
        dn    = -1;
        for (int c = 1; c <= budget && dn < 0; c++) begin
            @(negedge clk);
            if (bus.out_valid && first < 0) first = c;
            if (bus.done) dn = c;
        end
        check({nm, "_done_seen"}, 64'(dn > 0), 64'd1);
    endtask

    task automatic post_checks(input string nm, input int r0, input int d0, input int h0, input int len);
        @(negedge clk);
        #1;
        check({nm, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({nm, "_reads"}, 64'(popped - r0), 64'((len + EPW - 1) / EPW));
        check({nm, "_done_cnt"}, 64'(done_count - d0), 64'd1);
        check({nm, "_handshakes"}, 64'(hs_count - h0), 64'(len));
        check({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    // One complete row with preloaded words; cycle timing is checked when ready is held high.
    task automatic run_row(input string nm, input int len, input bit timed);
        int r0, d0, h0, first, dn, nw;
        r0 = popped;
        d0 = done_count;
        h0 = hs_count;
        nw = (len + EPW - 1) / EPW;
        issue_start(len);
        wait_done(nm, len * 8 + 60, first, dn);
        if (timed) begin
            if (len == 0) begin
                check({nm, "_done_cycle"}, 64'(dn), 64'd1);
            end else begin
                check({nm, "_first_valid"}, 64'(first), 64'd3);
                check({nm, "_done_cycle"}, 64'(dn), 64'(3 + len + 2 * (nw - 1)));
            end
        end
        post_checks(nm, r0, d0, h0, len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, d0, h0, first, dn, len;
        logic found;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.row_len = '0;
        ready_fixed = 1'b1;
        rand_mode   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({bus.fifo_read_request, bus.out_valid, bus.out_last, bus.busy, bus.done}), 64'd0);
        check("rst_addr_data", 64'({bus.out_addr, bus.out_data}), 64'd0);
        #2 reset = 1'b0;
        tick();
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Single word, row of 4.
        row_words.delete();
        row_words.push_back(64'h0004_0003_0002_0001);
        push_word(64'h0004_0003_0002_0001);
        run_row("row4", 4, 1'b1);

        // Two words, row of 6: last two elements of the second word are dropped.
        row_words.delete();
        row_words.push_back(64'h0004_0003_0002_0001);
        row_words.push_back(64'h0008_0007_0006_0005);
        push_word(row_words[0]);
        push_word(row_words[1]);
        run_row("row6", 6, 1'b1);

        // FIFO empty for 5 cycles after start.
        rand_words(1, 1'b0);
        r0 = popped; d0 = done_count; h0 = hs_count;
        issue_start(4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("empty_no_req", 64'(bus.fifo_read_request), 64'd0);
            check("empty_no_valid", 64'(bus.out_valid), 64'd0);
        end
        tick();
        push_word(row_words[0]);
        #1;
        check("empty_req_rise", 64'(bus.fifo_read_request), 64'd1);
        check("empty_valid_before_capt", 64'(bus.out_valid), 64'd0);
        wait_done("empty", 100, first, dn);
        post_checks("empty", r0, d0, h0, 4);

        // Random backpressure on a row of 8.
        rand_words(2, 1'b1);
        rand_mode = 1'b1;
        run_row("bp8", 8, 1'b0);
        rand_mode = 1'b0;

        // Zero-length row: no read, done on the next cycle.
        row_words.delete();
        run_row("len0", 0, 1'b1);

        // Start while busy must be ignored.
        rand_words(1, 1'b1);
        r0 = popped; d0 = done_count; h0 = hs_count;
        issue_start(4);
        bus.start   = 1'b1;
        bus.row_len = LW'(8);
        tick();
        bus.start = 1'b0;
        wait_done("busy_start", 100, first, dn);
        repeat (4) @(negedge clk);
        post_checks("busy_start", r0, d0, h0, 4);

        // Asynchronous reset in the middle of draining element 2.
        rand_words(1, 1'b1);
        issue_start(4);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_addr == AW'(2)) found = 1'b1;
        end
        check("rst_reach_elem2", 64'(found), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({bus.fifo_read_request, bus.out_valid, bus.out_last, bus.busy, bus.done}), 64'd0);
        check("rst_mid_addr_data", 64'({bus.out_addr, bus.out_data}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        tick();
        rand_words(2, 1'b1);
        run_row("after_rst", 5, 1'b1);

        // Randomized rows, mixed backpressure.
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, 40);
            rand_words((len + EPW - 1) / EPW, 1'b1);
            rand_mode = 1'($urandom_range(0, 1));
            run_row("rand_row", len, !rand_mode);
        end
        rand_mode = 1'b0;

        // Maximum-length row.
        rand_words(MRL / EPW, 1'b1);
        run_row("max_row", MRL, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_row_unpacker.md
Name: fifo_row_unpacker

Overview:
- Sits directly downstream of the PE's width-converting input FIFO, on the read side.
- Pops packed R_DATA_WIDTH words from the FIFO and unpacks each into ELEM_WIDTH elements.
- Streams the elements one per handshake to the scratchpad writer, with a scratchpad address and a last-of-row flag.
- One row transfer of row_len elements is launched per start pulse.

Parameters:
- R_DATA_WIDTH, 64: width of the FIFO read word.
- ELEM_WIDTH, 16: width of one unpacked element. R_DATA_WIDTH/ELEM_WIDTH must be an integer power of 2, at least 1.
- MAX_ROW_LEN, 256: maximum elements per row. Derived: ADDR_W = clog2(MAX_ROW_LEN), LEN_W = clog2(MAX_ROW_LEN+1), EPW = R_DATA_WIDTH/ELEM_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; launches a row transfer when idle.
- row_len  input  LEN_W  element count; sampled only on an accepted start.
- fifo_empty_flag  input  1  FIFO empty indication.
- fifo_read_request  output  1  FIFO pop request.
- fifo_rd_data  input  R_DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_request.
- out_valid  output  1  element valid.
- out_ready  input  1  downstream accepts the element.
- out_data  output  ELEM_WIDTH  element value.
- out_addr  output  ADDR_W  element index within the row (scratchpad address).
- out_last  output  1  high with the final element of the row.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at the end of a row.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high on port reset.
- Reset effect: forces state IDLE and clears word register, elem_idx, out_addr and remaining. All outputs go 0, including fifo_read_request, out_valid, out_last, busy and done. Reset asserted mid-transfer aborts the row immediately; a FIFO word already popped is lost.
- States:
  - IDLE: start with row_len>0 latches remaining=row_len, clears out_addr and elem_idx, goes to FETCH. start with row_len==0 goes to DONE with no FIFO read. start is ignored in every state other than IDLE.
  - FETCH: fifo_read_request = !fifo_empty_flag, combinational. If the request is high, next state is CAPT; otherwise stay in FETCH. The FIFO is never popped while it is empty.
  - CAPT: word register <= fifo_rd_data; next state DRAIN. fifo_read_request is 0.
  - DRAIN: out_valid=1. out_data = word[elem_idx*ELEM_WIDTH +: ELEM_WIDTH], LSB-first (element 0 = bits [ELEM_WIDTH-1:0]). out_last = (remaining==1).
    - Handshake: on out_valid&&out_ready, out_addr++, elem_idx++ (mod EPW), remaining--.
    - If remaining was 1, go to DONE; unconsumed elements of that word are discarded.
    - Else if elem_idx was EPW-1, go to FETCH.
    - Else stay in DRAIN.
    - out_data, out_addr and out_last are held stable while out_valid && !out_ready.
- DONE: done=1 for exactly one cycle; next state IDLE.
- Latency and throughput: start to first out_valid is 3 cycles with the FIFO non-empty (IDLE->FETCH->CAPT->DRAIN). Per word: EPW accepted handshakes plus 2 overhead cycles; no prefetch overlap.
- Width rules: remaining is LEN_W bits and never underflows. out_addr wraps only past MAX_ROW_LEN-1, which is unreachable for legal row_len. row_len > MAX_ROW_LEN is illegal and its behaviour is undefined.
- No valid-ready combinational path: out_valid does not depend on out_ready.

Test Plan:
- Defaults. FIFO preloaded with one word 0x0004_0003_0002_0001, start with row_len=4, out_ready=1 → read_request high exactly 1 cycle; out_data 1,2,3,4 at out_addr 0..3 on consecutive cycles; out_last only with 4; done pulse 1 cycle later; busy falls.
- row_len=6, two words {0x..0004_0003_0002_0001, 0x0008_0007_0006_0005} → elements 1..6 emitted; 2 reads; 7 and 8 dropped; out_last with 6 at addr 5.
- FIFO empty for 5 cycles after start, then one word arrives → fifo_read_request stays 0 while empty and rises the cycle fifo_empty_flag falls; no out_valid before CAPT.
- Random out_ready backpressure on row_len=8 → out_data, out_addr and out_last stable while stalled; exactly 8 handshakes; order 1..8.
- start with row_len=0 → no FIFO read, done pulse the next cycle. A start pulse while busy is ignored: row length is unchanged and no extra done.
- reset asserted mid-DRAIN at element 2 → outputs 0 the same cycle (async). After release, a new start transfers a fresh row correctly from addr 0.
